// File: rtl/pos_pkg.sv
// Shared types and defaults for the position-to-mask decoder.
package pos_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } pos_dec_state_t;

  localparam int POS_W_DEFAULT = 4;

endpackage

// File: rtl/pos_onehot_dec.sv
// Combinational decode of a bit position into a W-bit one-hot vector.
module pos_onehot_dec #(
  parameter  int W  = 4,
  localparam int PW = $clog2(W)
) (
  input  logic [PW-1:0] i_pos,
  output logic [W-1:0]  o_onehot
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  assign o_onehot = ONE << i_pos;

endmodule

// File: rtl/pos_mask_decoder.sv
// Rebuilds a W-bit mask from a stream of bit positions and offers each closed
// frame downstream on a valid/ready handshake.
module pos_mask_decoder
  import pos_pkg::*;
#(
  parameter  int W    = POS_W_DEFAULT,
  parameter  int NPOS = 2,
  localparam int PW   = $clog2(W),
  localparam int CW   = $clog2(NPOS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_pos,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_mask,
  output logic [CW-1:0] out_count,
  output logic          out_dup
);

  localparam logic [CW-1:0] LAST_SLOT = CW'(NPOS - 1);

  pos_dec_state_t r_state;
  pos_dec_state_t w_next_state;
  logic [W-1:0]   r_mask;
  logic [CW-1:0]  r_count;
  logic           r_dup;
  logic [W-1:0]   w_onehot;
  logic           w_accept;
  logic           w_close;
  logic           w_release;

  pos_onehot_dec #(.W(W)) u_dec (
    .i_pos    (in_pos),
    .o_onehot (w_onehot)
  );

  assign in_ready  = (r_state != S_OUT);
  assign out_valid = (r_state == S_OUT);
  assign w_accept  = in_valid & in_ready;
  // The frame closes on the position that fills the last slot or carries in_last.
  assign w_close   = w_accept & ((r_count == LAST_SLOT) | in_last);
  assign w_release = out_valid & out_ready;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_ACC: begin
        if (w_close)       w_next_state = S_OUT;
        else if (w_accept) w_next_state = S_ACC;
      end
      S_OUT: begin
        if (out_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Single register stage: frame accumulation and handshake state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_count <= '0;
      r_dup   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_mask  <= r_mask | w_onehot;
        r_dup   <= r_dup | r_mask[in_pos];
        r_count <= r_count + CW'(1);
      end else if (w_release) begin
        r_mask  <= '0;
        r_count <= '0;
        r_dup   <= 1'b0;
      end
    end
  end

  assign out_mask  = r_mask;
  assign out_count = r_count;
  assign out_dup   = r_dup;

endmodule

// File: tb/tb_pos_mask_decoder.sv
// Directed and randomized frames for pos_mask_decoder (W=4, NPOS=2) with a
// scoreboard of expected frame results.
module tb_pos_mask_decoder;

  localparam int W    = 4;
  localparam int NPOS = 2;

  typedef struct packed {
    logic [3:0] mask;
    logic [1:0] count;
    logic       dup;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_pos;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_mask;
  logic [1:0] out_count;
  logic       out_dup;

  int total = 0;
  int bad   = 0;

  exp_t       sb_q[$];
  logic [3:0] m_mask;
  int         m_count;
  logic       m_dup;

  pos_mask_decoder #(.W(W), .NPOS(NPOS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pos    (in_pos),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mask  (out_mask),
    .out_count (out_count),
    .out_dup   (out_dup)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_mask  = '0;
    m_count = 0;
    m_dup   = 1'b0;
  endtask

  // Offer one position; predicts the frame result when this position closes it.
  task automatic send(input int pos, input bit last);
    bit   closing;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_pos   = 2'(pos);
    in_last  = last;
    chk("in_ready_pre", {31'd0, in_ready}, 32'd1);
    closing = last || (m_count + 1 == NPOS);
    m_dup   = m_dup | m_mask[pos];
    m_mask  = m_mask | (4'b0001 << pos);
    m_count = m_count + 1;
    if (closing) begin
      e.mask  = m_mask;
      e.count = 2'(m_count);
      e.dup   = m_dup;
      sb_q.push_back(e);
      model_clear();
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("out_valid_latency", {31'd0, out_valid}, {31'd0, closing});
  endtask

  // Hold the frame for 'hold' cycles (optionally poking in_valid), then accept it.
  task automatic expect_out(input int hold, input bit poke);
    exp_t e;
    chk("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
    if (sb_q.size() == 0) return;
    e = sb_q[0];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (poke) begin
        in_valid = 1'b1;
        in_pos   = 2'd0;
        in_last  = 1'b1;
      end
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_mask", {28'd0, out_mask}, {28'd0, e.mask});
      chk("hold_count", {30'd0, out_count}, {30'd0, e.count});
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    e = sb_q.pop_front();
    chk("out_valid", {31'd0, out_valid}, 32'd1);
    chk("out_mask", {28'd0, out_mask}, {28'd0, e.mask});
    chk("out_count", {30'd0, out_count}, {30'd0, e.count});
    chk("out_dup", {31'd0, out_dup}, {31'd0, e.dup});
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("post_valid", {31'd0, out_valid}, 32'd0);
    chk("post_mask", {28'd0, out_mask}, 32'd0);
    chk("post_count", {30'd0, out_count}, 32'd0);
    chk("post_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int p0;
    bit l0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_pos    = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    model_clear();

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mask", {28'd0, out_mask}, 32'd0);
    chk("rst_count", {30'd0, out_count}, 32'd0);
    chk("rst_dup", {31'd0, out_dup}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    send(2, 0);
    send(0, 0);
    expect_out(0, 0);

    send(3, 0);
    send(3, 0);
    expect_out(0, 0);

    send(1, 1);
    expect_out(0, 0);

    send(3, 0);
    send(1, 0);
    expect_out(5, 1);

    send(1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    chk("midrst_mask", {28'd0, out_mask}, 32'd0);
    chk("midrst_count", {30'd0, out_count}, 32'd0);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(0, 0);
    send(2, 0);
    expect_out(0, 0);

    for (int f = 0; f < 8; f++) begin
      p0 = $urandom_range(0, 3);
      l0 = 1'($urandom_range(0, 1));
      send(p0, l0);
      if (!l0) send($urandom_range(0, 3), 1'($urandom_range(0, 1)));
      expect_out($urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
